// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Shift-add multiply (or single-cycle when FAST_MUL), restoring divide, sign fix-up in a final cycle.
module md_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] opb;
  logic             neg_q, neg_r, is_div, div_by_zero;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             start_md_c, start_mt_c, signed_op_c, fix_wr_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [W2-1:0]    fast_prod_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [W2-1:0]    mul_step_c;
  logic [WIDTH:0]   div_sh_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [W2-1:0]    div_step_c;
  logic [W2-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

  // Issue decode and operand magnitudes
  always_comb begin
    start_md_c  = Start && !Flush && !Op[2];
    start_mt_c  = Start && !Flush && Op[2] && !Op[1];
    signed_op_c = !Op[0];
    mag_a_c     = (signed_op_c && SrcA[WIDTH-1]) ? WIDTH'(-SrcA) : SrcA;
    mag_b_c     = (signed_op_c && SrcB[WIDTH-1]) ? WIDTH'(-SrcB) : SrcB;
    fast_prod_c = W2'(W2'(mag_a_c) * W2'(mag_b_c));
    fix_wr_c    = (state == S_FIX) && !Flush;
  end

  // One iteration of each algorithm; acc holds {partial/remainder, multiplier/quotient}
  always_comb begin
    mul_sum_c  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opb};
    mul_step_c = acc[0] ? {mul_sum_c, acc[WIDTH-1:1]} : {1'b0, acc[W2-1:1]};
    div_sh_c   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_ge_c   = (div_sh_c >= {1'b0, opb});
    div_rem_c  = WIDTH'(div_sh_c - {1'b0, opb});
    div_step_c = div_ge_c ? {div_rem_c, acc[WIDTH-2:0], 1'b1} : {acc[W2-2:0], 1'b0};
  end

  // Sign correction applied in the FIX cycle
  always_comb begin
    prod_fix_c = neg_q ? W2'(-acc) : acc;
    quo_fix_c  = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix_c  = neg_r ? WIDTH'(-acc[W2-1:WIDTH]) : acc[W2-1:WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_md_c) begin
          if (Op[1])         state_nx = S_DIV;
          else if (FAST_MUL) state_nx = S_FIX;
          else               state_nx = S_MUL;
        end
      end
      S_MUL, S_DIV: if (cnt == '0) state_nx = S_FIX;
      S_FIX:        state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
    if (Flush) state_nx = S_IDLE;
  end

  // State register and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != S_IDLE);
      done_q <= fix_wr_c;
      dz_q   <= fix_wr_c && is_div && div_by_zero;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opb         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_div      <= 1'b0;
      div_by_zero <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_md_c) begin
            opb         <= mag_b_c;
            neg_q       <= signed_op_c && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_r       <= signed_op_c && SrcA[WIDTH-1];
            is_div      <= Op[1];
            div_by_zero <= (SrcB == '0);
            cnt         <= CW'(WIDTH - 1);
            if (!Op[1] && FAST_MUL) acc <= fast_prod_c;
            else                    acc <= {{WIDTH{1'b0}}, mag_a_c};
          end else if (start_mt_c) begin
            if (Op[0]) lo_q <= SrcA;
            else       hi_q <= SrcA;
          end
        end
        S_MUL: begin
          acc <= mul_step_c;
          cnt <= cnt - CW'(1);
        end
        S_DIV: begin
          acc <= div_step_c;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (fix_wr_c && !(is_div && div_by_zero)) begin
            if (is_div) begin
              hi_q <= rem_fix_c;
              lo_q <= quo_fix_c;
            end else begin
              hi_q <= prod_fix_c[W2-1:WIDTH];
              lo_q <= prod_fix_c[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: iterative and fast-multiply instances driven in parallel,
// checked against an arithmetic reference model of the MIPS HI/LO semantics.
module tb_md_unit;
  localparam int unsigned W = 32;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO = 3'd5;

  logic         clk = 1'b0;
  logic         rst, Start, Flush;
  logic [2:0]   Op;
  logic [W-1:0] SrcA, SrcB;
  logic         busy_s, done_s, dz_s, busy_f, done_f, dz_f;
  logic [W-1:0] hi_s, lo_s, hi_f, lo_f;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_hi_s, exp_lo_s, exp_hi_f, exp_lo_f;

  md_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
    .Busy(busy_s), .Done(done_s), .DivZero(dz_s), .Hi(hi_s), .Lo(lo_s));

  md_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
    .Busy(busy_f), .Done(done_f), .DivZero(dz_f), .Hi(hi_f), .Lo(lo_f));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operation
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                input logic [W-1:0] hi_in, lo_in,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output bit dz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = hi_in;
    lo = lo_in;
    dz = 1'b0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = 64'(ua * ub); hi = p[63:32]; lo = p[31:0]; end
      OP_DIV: begin
        if (b == 0) dz = 1'b1;
        else begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); lo = p[31:0];
          p = 64'(sr); hi = p[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) dz = 1'b1;
        else begin lo = a / b; hi = a % b; end
      end
      OP_MTHI: hi = a;
      OP_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, input string name);
    logic [W-1:0] hs, ls, hf, lf;
    bit dze_s, dze_f, bad_s, bad_f, dzo_s, dzo_f;
    int lat_s, lat_f, at_s, at_f;
    model(op, a, b, exp_hi_s, exp_lo_s, hs, ls, dze_s);
    model(op, a, b, exp_hi_f, exp_lo_f, hf, lf, dze_f);
    lat_s = W + 2;
    lat_f = (op[2:1] == 2'b00) ? 2 : W + 2;
    at_s = -1; at_f = -1; bad_s = 0; bad_f = 0; dzo_s = 0; dzo_f = 0;
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0; Op = 3'($urandom_range(0, 7)); SrcA = $urandom; SrcB = $urandom;
    for (int c = 1; c <= W + 4; c++) begin
      if (busy_s !== 1'(c < lat_s)) bad_s = 1;
      if (busy_f !== 1'(c < lat_f)) bad_f = 1;
      if (done_s === 1'b1) begin if (at_s < 0) at_s = c; else bad_s = 1; dzo_s = dz_s; end
      else if (dz_s !== 1'b0) bad_s = 1;
      if (done_f === 1'b1) begin if (at_f < 0) at_f = c; else bad_f = 1; dzo_f = dz_f; end
      else if (dz_f !== 1'b0) bad_f = 1;
      if (c != W + 4) tick();
    end
    total_cnt++; if (at_s !== lat_s) $display("FAIL %s slow done cycle: got %0d want %0d", name, at_s, lat_s); else pass_cnt++;
    total_cnt++; if (at_f !== lat_f) $display("FAIL %s fast done cycle: got %0d want %0d", name, at_f, lat_f); else pass_cnt++;
    total_cnt++; if (bad_s !== 1'b0) $display("FAIL %s slow busy/done/divzero shape: got bad=1 want 0", name); else pass_cnt++;
    total_cnt++; if (bad_f !== 1'b0) $display("FAIL %s fast busy/done/divzero shape: got bad=1 want 0", name); else pass_cnt++;
    total_cnt++; if (dzo_s !== dze_s) $display("FAIL %s slow DivZero: got %0b want %0b", name, dzo_s, dze_s); else pass_cnt++;
    total_cnt++; if (dzo_f !== dze_f) $display("FAIL %s fast DivZero: got %0b want %0b", name, dzo_f, dze_f); else pass_cnt++;
    total_cnt++; if (hi_s !== hs) $display("FAIL %s slow Hi: got %h want %h", name, hi_s, hs); else pass_cnt++;
    total_cnt++; if (lo_s !== ls) $display("FAIL %s slow Lo: got %h want %h", name, lo_s, ls); else pass_cnt++;
    total_cnt++; if (hi_f !== hf) $display("FAIL %s fast Hi: got %h want %h", name, hi_f, hf); else pass_cnt++;
    total_cnt++; if (lo_f !== lf) $display("FAIL %s fast Lo: got %h want %h", name, lo_f, lf); else pass_cnt++;
    exp_hi_s = hs; exp_lo_s = ls; exp_hi_f = hf; exp_lo_f = lf;
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [W-1:0] a, input string name);
    logic [W-1:0] h, l;
    bit dz;
    model(op, a, 32'd0, exp_hi_s, exp_lo_s, h, l, dz);
    Start = 1'b1; Op = op; SrcA = a; SrcB = $urandom;
    tick();
    Start = 1'b0;
    total_cnt++; if (busy_s !== 1'b0 || done_s !== 1'b0) $display("FAIL %s busy/done: got %b%b want 00", name, busy_s, done_s); else pass_cnt++;
    total_cnt++; if (hi_s !== h || lo_s !== l) $display("FAIL %s slow hi/lo: got %h/%h want %h/%h", name, hi_s, lo_s, h, l); else pass_cnt++;
    total_cnt++; if (hi_f !== h || lo_f !== l) $display("FAIL %s fast hi/lo: got %h/%h want %h/%h", name, hi_f, lo_f, h, l); else pass_cnt++;
    exp_hi_s = h; exp_lo_s = l; exp_hi_f = h; exp_lo_f = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
    tick(); tick();
    total_cnt++; if ({hi_s, lo_s} !== '0) $display("FAIL reset hi/lo: got %h/%h want 0/0", hi_s, lo_s); else pass_cnt++;
    total_cnt++; if ({busy_s, done_s, dz_s} !== 3'b000) $display("FAIL reset status: got %b want 000", {busy_s, done_s, dz_s}); else pass_cnt++;
    total_cnt++; if ({hi_f, lo_f, busy_f, done_f} !== '0) $display("FAIL reset fast: got %h/%h %b%b want zeros", hi_f, lo_f, busy_f, done_f); else pass_cnt++;
    exp_hi_s = '0; exp_lo_s = '0; exp_hi_f = '0; exp_lo_f = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg3x5");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7_2");
    run_op(OP_DIVU,  32'd7,         32'd2,         "divu_7_2");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_m2");
  endtask

  task automatic test_mt_divzero();
    run_mt(OP_MTHI, 32'h1234, "mthi");
    run_mt(OP_MTLO, 32'h5678, "mtlo");
    run_op(OP_DIVU, 32'd9, 32'd0, "divu_by_zero");
    run_op(OP_DIV,  32'hFFFF_FF00, 32'd0, "div_by_zero");
  endtask

  task automatic test_flush();
    logic [W-1:0] hf, lf;
    bit dz, done_seen;
    model(OP_MULT, 32'd3, 32'd4, exp_hi_f, exp_lo_f, hf, lf, dz);
    done_seen = 0;
    Start = 1'b1; Op = OP_MULT; SrcA = 32'd3; SrcB = 32'd4;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= W + 4; c++) begin
      if (done_s === 1'b1 || dz_s === 1'b1) done_seen = 1;
      if (c == 10) begin
        total_cnt++; if (busy_s !== 1'b1) $display("FAIL flush busy before: got %b want 1", busy_s); else pass_cnt++;
      end
      if (c == 11) begin
        total_cnt++; if (busy_s !== 1'b0) $display("FAIL flush slow busy after: got %b want 0", busy_s); else pass_cnt++;
        total_cnt++; if (busy_f !== 1'b0) $display("FAIL flush fast busy after: got %b want 0", busy_f); else pass_cnt++;
      end
      if (c == 5) begin Start = 1'b1; Op = OP_DIVU; SrcA = 32'd50; SrcB = 32'd3; end
      if (c == 6) Start = 1'b0;
      if (c == 10) Flush = 1'b1;
      if (c == 11) Flush = 1'b0;
      if (c != W + 4) tick();
    end
    total_cnt++; if (done_seen !== 1'b0) $display("FAIL flush slow done seen: got 1 want 0"); else pass_cnt++;
    total_cnt++; if (hi_s !== exp_hi_s || lo_s !== exp_lo_s) $display("FAIL flush slow hi/lo: got %h/%h want %h/%h", hi_s, lo_s, exp_hi_s, exp_lo_s); else pass_cnt++;
    total_cnt++; if (hi_f !== hf || lo_f !== lf) $display("FAIL flush fast hi/lo: got %h/%h want %h/%h", hi_f, lo_f, hf, lf); else pass_cnt++;
    exp_hi_f = hf; exp_lo_f = lf;
  endtask

  task automatic test_idle_gating();
    bit seen;
    Start = 1'b1; Op = OP_MTHI; SrcA = 32'hDEAD_BEEF; Flush = 1'b1;
    tick();
    Op = OP_DIV; SrcB = 32'd3;
    tick();
    Start = 1'b0; Flush = 1'b0;
    total_cnt++; if (busy_s !== 1'b0 || hi_s !== exp_hi_s) $display("FAIL flush_start_idle: got busy=%b hi=%h want 0/%h", busy_s, hi_s, exp_hi_s); else pass_cnt++;
    Start = 1'b1; Op = 3'b110; SrcA = 32'hAAAA_5555;
    tick();
    Op = 3'b111;
    tick();
    Start = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (busy_s === 1'b1 || done_s === 1'b1 || busy_f === 1'b1 || done_f === 1'b1) seen = 1;
      tick();
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL undefined_op activity: got 1 want 0"); else pass_cnt++;
    total_cnt++; if (hi_s !== exp_hi_s || lo_s !== exp_lo_s) $display("FAIL undefined_op hi/lo: got %h/%h want %h/%h", hi_s, lo_s, exp_hi_s, exp_lo_s); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    Start = 1'b1; Op = OP_DIVU; SrcA = 32'd100; SrcB = 32'd7;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({hi_s, lo_s, busy_s, done_s} !== '0) $display("FAIL reset_midop slow: got %h/%h %b%b want zeros", hi_s, lo_s, busy_s, done_s); else pass_cnt++;
    total_cnt++; if ({hi_f, lo_f, busy_f, done_f} !== '0) $display("FAIL reset_midop fast: got %h/%h %b%b want zeros", hi_f, lo_f, busy_f, done_f); else pass_cnt++;
    exp_hi_s = '0; exp_lo_s = '0; exp_hi_f = '0; exp_lo_f = '0;
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_after_reset");
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(1, 15));
      if (i % 4 == 2) b = -32'($urandom_range(1, 15));
      if (i % 6 == 5) b = '0;
      run_op(op, a, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, "b2b_mult");
    run_op(OP_DIV,  32'h8000_0001, 32'd3,         "b2b_div");
    run_mt(OP_MTLO, 32'hCAFE_F00D, "b2b_mtlo");
    run_op(OP_MULTU, 32'h8000_0000, 32'd2, "b2b_multu");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_divzero();
    test_flush();
    test_idle_gating();
    test_reset_midop();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative multiply/divide unit with HI/LO registers for the MIPS32 pipeline. It sits beside the ALU in EX and adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support. It is width-parametrised and has an optional single-cycle multiply. While an operation is in flight, Busy drives the pipeline stall logic, and MFHI/MFLO read Hi/Lo directly.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (even, >= 4)
FAST_MUL, 0, 1 = multiply completes after 1 Busy cycle; 0 = iterative shift-add

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Start  in  1  issue operation; sampled only in IDLE
Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
SrcA  in  WIDTH  rs operand (dividend / multiplicand / MT data)
SrcB  in  WIDTH  rt operand (divisor / multiplier)
Flush  in  1  abort in-flight operation (branch/exception flush)
Busy  out  1  operation in progress; stall MFHI/MFLO and any new mul/div
Done  out  1  one-cycle pulse: Hi/Lo just updated by a mul/div
DivZero  out  1  one-cycle pulse with Done when the divisor was 0
Hi  out  WIDTH  HI register
Lo  out  WIDTH  LO register

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state IDLE. Reset mid-operation aborts it with no result.
- States: IDLE, MUL, DIV, FIX.
- IDLE + Start (Op MULT..DIVU) + !Flush:
  - Capture SrcA/SrcB into internal regs; later input changes are ignored.
  - Signed ops capture magnitudes plus sign flags.
  - Go to MUL or DIV.
- MUL/DIV iteration:
  - One bit per cycle, WIDTH cycles.
  - MUL: shift-add over a 2*WIDTH accumulator.
  - DIV: restoring shift-subtract.
  - Then FIX for 1 cycle: apply sign correction and write Hi/Lo, then return to IDLE.
- Timing, Start sampled at edge 0:
  - Busy=1 in cycles 1..WIDTH+1.
  - Hi/Lo written at edge WIDTH+1.
  - Done=1 and Busy=0 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- FAST_MUL=1: multiply skips iteration. Busy is high for cycle 1 only, and Hi/Lo and Done appear in cycle 2. Divide timing is unchanged.
- MULT/MULTU result: {Hi,Lo} = full 2*WIDTH product (two's complement for MULT).
- DIV/DIVU result: Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV MIN/-1: Lo=MIN, Hi=0 (wrap, no trap).
- Divisor 0: full latency. Hi/Lo are unchanged; DivZero pulses together with Done.
- MTHI/MTLO in IDLE:
  - Hi (or Lo) = SrcA at the sampling edge.
  - No Busy, no Done; visible the next cycle.
- Start while Busy: ignored, no queueing. The pipeline must stall instead.
- Flush:
  - In any non-IDLE state: return to IDLE next edge, Busy=0 next cycle, no Done, Hi/Lo retained.
  - Flush with Start in IDLE: Flush wins and Start is ignored (including MT ops).
  - Flush in the FIX cycle also suppresses the write.
- Undefined Op with Start: no-op, state stays IDLE.
- Done and DivZero are never high outside the single cycle after the FIX write.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, WIDTH=32 -> Busy cycles 1–33; cycle 34: Done=1, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT SrcA=0xFFFFFFFD(−3), SrcB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Repeat with FAST_MUL=1 -> same values, Done in cycle 2.
- DIV −7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/2 -> Lo=3, Hi=1. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- MTHI 0x1234, MTLO 0x5678, then DIVU 9/0 -> Done and DivZero both high in cycle 34; Hi=0x1234, Lo=0x5678.
- MULT 3×4, Start re-asserted (DIVU) in cycle 5, Flush in cycle 10 -> Busy=0 in cycle 11, no Done, Hi/Lo unchanged; the cycle-5 Start has no effect.
- DIVU 100/7 with rst in cycle 5 -> cycle 6: Hi=Lo=0, Busy=0. A new DIVU 100/7 then yields Lo=14, Hi=2.
